// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filtering, frame
// checking, a frame timeout, a show-ahead scan-code FIFO and a history of
// the last four accepted bytes.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   kclk, kdata       asynchronous PS/2 clock and data lines
//   rd_en             pop request (ignored while empty)
//   ovf_clr           clears the sticky overflow flag
//   rd_data           FIFO head byte (show-ahead)
//   rd_valid          FIFO not empty
//   fifo_count        FIFO occupancy, 0..FIFO_DEPTH
//   overflow          sticky: a good byte was dropped by a full FIFO
//   parity_err        one-cycle pulse on a parity failure
//   frame_err         one-cycle pulse on a stop bit of 0
//   timeout_err       one-cycle pulse when a frame stalls
//   keycode_hist      last four accepted bytes, newest in [7:0]
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         kclk,
  input  logic                         kdata,
  input  logic                         rd_en,
  input  logic                         ovf_clr,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         timeout_err,
  output logic [31:0]                  keycode_hist
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Line conditioning: index 0 = kclk, index 1 = kdata
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_filt;
  logic [1:0][FW-1:0] r_fcnt;
  logic               r_kclk_d;
  logic               w_sample;
  logic               w_sdata;

  // Receiver
  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_par;
  logic [TW-1:0]      r_to_cnt;
  logic               w_to_hit;
  logic               w_start;
  logic               w_shift;
  logic               w_par_cap;
  logic               w_stop;
  logic               w_par_ok;
  logic               r_push;
  logic [7:0]         r_push_byte;
  logic               r_parity_err;
  logic               r_frame_err;
  logic               r_timeout_err;
  logic [31:0]        r_hist;

  // FIFO
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_valid;
  logic [7:0]         r_rd_data;
  logic               r_overflow;
  logic               w_full;
  logic               w_pop;
  logic               w_do_push;
  logic               w_drop;
  logic [AW-1:0]      w_rd_ptr_nxt;
  logic [CW-1:0]      w_count_nxt;
  logic [7:0]         w_head_nxt;

  // Synchronizer and glitch filter; a filtered line flips after FILT_LEN
  // consecutive synchronized samples disagree with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_filt   <= 2'b11;
      r_fcnt   <= '0;
      r_kclk_d <= 1'b1;
    end else begin
      r_sync1  <= {kdata, kclk};
      r_sync2  <= r_sync1;
      r_kclk_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILT_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign w_sample = r_kclk_d & ~r_filt[0];
  assign w_sdata  = r_filt[1];

  // Timeout fires on the edge where the counter would reach TIMEOUT_CYC-1,
  // so the pulse lands TIMEOUT_CYC cycles after the last sample.
  assign w_to_hit = (r_state != S_IDLE) && !w_sample &&
                    (r_to_cnt == TW'(TIMEOUT_CYC - 2));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_to_hit) begin
      w_state_nxt = S_IDLE;
    end else if (w_sample) begin
      unique case (r_state)
        S_IDLE:   if (!w_sdata) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM output decode
  always_comb begin
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_par_cap = 1'b0;
    w_stop    = 1'b0;
    if (w_sample) begin
      unique case (r_state)
        S_IDLE:   w_start   = ~w_sdata;
        S_DATA:   w_shift   = 1'b1;
        S_PARITY: w_par_cap = 1'b1;
        S_STOP:   w_stop    = 1'b1;
        default:  w_start   = 1'b0;
      endcase
    end
  end

  assign w_par_ok = ^{r_shift, r_par};

  // Frame datapath, error pulses and byte hand-off to the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_to_cnt      <= '0;
      r_push        <= 1'b0;
      r_push_byte   <= '0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_sample || w_to_hit) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + TW'(1);

      if (w_start) r_bit_cnt <= '0;
      if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {w_sdata, r_shift[7:1]};
      end
      if (w_par_cap) r_par <= w_sdata;

      r_push        <= w_stop & w_par_ok & w_sdata;
      r_push_byte   <= r_shift;
      r_parity_err  <= w_stop & ~w_par_ok;
      r_frame_err   <= w_stop & ~w_sdata;
      r_timeout_err <= w_to_hit;
    end
  end

  // History shifts on every accepted byte, even one the FIFO drops
  always_ff @(posedge clk) begin
    if (!rst_n)      r_hist <= '0;
    else if (r_push) r_hist <= {r_hist[23:0], r_push_byte};
  end

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = rd_en & r_valid;
  assign w_do_push = r_push & (~w_full | w_pop);
  assign w_drop    = r_push & w_full & ~w_pop;

  // Next FIFO occupancy and head, with write-through when the new byte
  // lands in the head slot
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_pop) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    w_count_nxt = r_count;
    if (w_do_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_do_push && w_pop) w_count_nxt = r_count - CW'(1);
    w_head_nxt = '0;
    if (w_count_nxt != '0) begin
      if (w_do_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = r_push_byte;
      else                                         w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (rst_n && w_do_push) r_mem[r_wr_ptr] <= r_push_byte;
  end

  // FIFO pointers, count, registered head and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_valid   <= (w_count_nxt != '0);
      r_rd_data <= w_head_nxt;
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_valid;
  assign fifo_count   = r_count;
  assign overflow     = r_overflow;
  assign parity_err   = r_parity_err;
  assign frame_err    = r_frame_err;
  assign timeout_err  = r_timeout_err;
  assign keycode_hist = r_hist;

endmodule
